// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the round-robin stream arbiter slice.
//   DEFAULT_WIDTH : default payload width per beat.
//   arb_state_e   : arbiter FSM encoding (IDLE = no packet open,
//                   LOCKED = packet open, grant pinned to one requester).
//   Stage word    : packed as {id, last, data}. data occupies the low WIDTH
//                   bits, last sits at bit WIDTH, id occupies the top IDW bits.
// -----------------------------------------------------------------------------
package stream_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Width of the stage word {id, last, data}.
    function automatic int stage_width(input int width, input int idw);
        return width + idw + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotate-priority picker. The search starts at ptr+1 (mod N)
// and wraps, so the requester at ptr has the lowest priority.
// Ports:
//   req_i         in  N    request bits
//   ptr_i         in  IDW  last-served index
//   grant_oh_o    out N    one-hot grant (all zero when no request)
//   grant_idx_o   out IDW  index of the granted requester (0 when none)
//   grant_valid_o out 1    at least one request present
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_oh_o,
    output logic [IDW-1:0] grant_idx_o,
    output logic           grant_valid_o
);

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        found         = 1'b0;
        idx           = '0;
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        // Walk the N candidates in priority order; the first hit wins.
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                found            = 1'b1;
                grant_oh_o[idx]  = 1'b1;
                grant_idx_o      = idx;
            end
        end
        grant_valid_o = found;
    end

endmodule

// File: rtl/single_stage_pipeline_reg.sv
// -----------------------------------------------------------------------------
// single_stage_pipeline_reg
// One-entry valid/ready register stage with full throughput: it accepts a new
// word in the same cycle the held word is drained.
// Handshake: a word moves when valid && ready are both high on a rising edge;
// valid never depends combinationally on ready of the same interface, and the
// held word stays stable while out_valid_o && !out_ready_i.
// Ports:
//   clk_i, resetn_i        clock, synchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake (in_ready_o = stage free)
//   in_data_i              upstream word
//   out_valid_o/out_ready_i downstream handshake
//   out_data_o             registered word
// -----------------------------------------------------------------------------
module single_stage_pipeline_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            // Data only updates on a real load so an idle stage keeps its
            // last word instead of capturing garbage.
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rr_stream_arbiter
// N-requester, packet-aware round-robin arbiter feeding one registered
// valid/ready stream. A grant is held from the first beat of a packet through
// the beat flagged last; the rotate pointer only moves at packet end.
// Handshake: a beat moves when valid && ready are high on a rising edge;
// in_ready is combinational from in_valid, state and out_ready; out_valid is
// registered and never depends on out_ready in the same cycle.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   in_valid/in_ready      per-requester handshake (at most one ready high)
//   in_data                requester i at [i*WIDTH +: WIDTH]
//   in_last                per-requester end-of-packet flag
//   out_valid/out_ready    output handshake
//   out_data/out_id/out_last registered beat, its source index and last flag
//   dbg_state              current FSM state (observation only)
// -----------------------------------------------------------------------------
module rr_stream_arbiter
    import stream_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = 4,
    localparam int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDW-1:0]     out_id,
    output logic               out_last,
    output arb_state_e         dbg_state
);

    localparam int SW = stage_width(WIDTH, IDW);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;

    logic [N-1:0]   pick_oh;
    logic [IDW-1:0] pick_idx;
    logic           pick_valid;

    logic [N-1:0]   grant_oh;
    logic [IDW-1:0] grant_idx;
    logic           grant_valid;

    logic           stage_free;
    logic           accept;
    logic [SW-1:0]  stage_din;
    logic [SW-1:0]  stage_dout;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i         (in_valid),
        .ptr_i         (ptr_q),
        .grant_oh_o    (pick_oh),
        .grant_idx_o   (pick_idx),
        .grant_valid_o (pick_valid)
    );

    // While a packet is open the owner keeps the grant even with in_valid low;
    // that cycle is a bubble rather than a chance for someone else.
    always_comb begin
        grant_oh    = pick_oh;
        grant_idx   = pick_idx;
        grant_valid = pick_valid;
        if (state_q == ST_LOCKED) begin
            grant_oh            = '0;
            grant_oh[lock_id_q] = 1'b1;
            grant_idx           = lock_id_q;
            grant_valid         = 1'b1;
        end
    end

    assign in_ready  = (resetn && grant_valid && stage_free) ? grant_oh : '0;
    assign accept    = in_valid[grant_idx] && in_ready[grant_idx];
    assign stage_din = {grant_idx, in_last[grant_idx], in_data[grant_idx*WIDTH +: WIDTH]};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            if (in_last[grant_idx]) begin
                state_d = ST_IDLE;
                ptr_d   = grant_idx;
            end else begin
                state_d   = ST_LOCKED;
                lock_id_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            lock_id_q <= '0;
            // ptr = N-1 makes requester 0 the first in line after reset.
            ptr_q     <= IDW'(N - 1);
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
        end
    end

    single_stage_pipeline_reg #(
        .W (SW)
    ) u_stage (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .in_valid_i  (accept),
        .in_ready_o  (stage_free),
        .in_data_i   (stage_din),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (stage_dout)
    );

    assign out_data  = stage_dout[WIDTH-1:0];
    assign out_last  = stage_dout[WIDTH];
    assign out_id    = stage_dout[WIDTH+1 +: IDW];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
module tb_rr_stream_arbiter;
    import stream_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int SRC_DEPTH = 64;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
        logic [W-1:0]   data;
    } beat_t;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           out_last;
    arb_state_e     dbg_state;

    always #5 clk = ~clk;

    rr_stream_arbiter #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .dbg_state (dbg_state)
    );

    // ---------------- sources, reference model, scoreboard ----------------
    logic [W-1:0] src_data [N][SRC_DEPTH];
    logic         src_last [N][SRC_DEPTH];
    int           src_wr [N];
    int           src_rd [N];

    // Reference arbitration state: packet open flag, owner, last-served index.
    bit m_locked;
    int m_owner;
    int m_ptr;

    beat_t exp_q[$];      // beats expected on the output, in order
    int    obs_id[$];     // ids observed on drained output beats
    logic [W-1:0] obs_data[$];

    logic [N-1:0] cyc_exp_rdy, cyc_got_rdy;
    logic         cyc_exp_ov, cyc_got_ov, cyc_chk_word;
    beat_t        cyc_exp_word, cyc_got_word;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic clear_all();
        exp_q.delete();
        obs_id.delete();
        obs_data.delete();
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = N - 1;
    endtask

    task automatic push_pkt(input int r, input int len, input logic [W-1:0] base);
        for (int k = 0; k < len; k++) begin
            src_data[r][src_wr[r]] = base + W'(k);
            src_last[r][src_wr[r]] = (k == len - 1);
            src_wr[r]++;
        end
    endtask

    task automatic apply_reset(input int cycles);
        resetn    = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b1;
        clear_all();
    endtask

    // Drives one cycle from the sources, predicts in_ready / output from the
    // model, records what the DUT shows, then advances the model at the edge.
    task automatic run_cycle(input logic ordy, input logic [N-1:0] mask);
        int  g, c;
        bit  gv, sf, acc;
        bit  have;
        resetn    = 1'b1;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            have = src_rd[i] < src_wr[i];
            in_valid[i]      = have && mask[i];
            in_last[i]       = have ? src_last[i][src_rd[i]] : 1'b0;
            in_data[i*W +: W] = have ? src_data[i][src_rd[i]] : '0;
        end
        #1;
        gv = 1'b0;
        g  = 0;
        if (m_locked) begin
            gv = 1'b1;
            g  = m_owner;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!gv && in_valid[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
        sf  = (exp_q.size() == 0) || ordy;
        acc = gv && sf && in_valid[g];
        cyc_exp_rdy = '0;
        if (gv && sf) cyc_exp_rdy[g] = 1'b1;
        cyc_got_rdy  = in_ready;
        cyc_exp_ov   = exp_q.size() > 0;
        cyc_got_ov   = out_valid;
        cyc_got_word = {out_id, out_last, out_data};
        cyc_chk_word = exp_q.size() > 0;
        cyc_exp_word = cyc_chk_word ? exp_q[0] : '0;
        @(posedge clk);
        if (exp_q.size() > 0 && ordy) begin
            obs_id.push_back(int'(cyc_got_word.id));
            obs_data.push_back(cyc_got_word.data);
            void'(exp_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back({IDW'(g), src_last[g][src_rd[g]], src_data[g][src_rd[g]]});
            if (src_last[g][src_rd[g]]) begin
                m_locked = 1'b0;
                m_ptr    = g;
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
            end
            src_rd[g]++;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn    = 1'b0;
        in_valid  = '1;
        in_last   = '1;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== '0) begin tests_failed++; $display("FAIL reset_in_ready: got %b exp 0000", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        tests_run++;
        if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
        tests_run++;
        if (out_id !== '0) begin tests_failed++; $display("FAIL reset_out_id: got %0d exp 0", out_id); end
        tests_run++;
        if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last: got %b exp 0", out_last); end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d exp IDLE", dbg_state); end
        resetn = 1'b1;
        clear_all();
    endtask

    task automatic test_fairness();
        apply_reset(2);
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < N; r++)
                push_pkt(r, 1, W'(32'h100 + r * 16 + k));
        for (int cyc = 0; cyc < 13; cyc++) begin
            run_cycle(1'b1, '1);
            tests_run++;
            if (cyc_got_rdy !== cyc_exp_rdy) begin tests_failed++; $display("FAIL fair_ready c%0d: got %b exp %b", cyc, cyc_got_rdy, cyc_exp_rdy); end
            tests_run++;
            if (cyc_got_ov !== cyc_exp_ov) begin tests_failed++; $display("FAIL fair_valid c%0d: got %b exp %b", cyc, cyc_got_ov, cyc_exp_ov); end
            if (cyc_chk_word) begin
                tests_run++;
                if (cyc_got_word !== cyc_exp_word) begin tests_failed++; $display("FAIL fair_beat c%0d: got %h exp %h", cyc, cyc_got_word, cyc_exp_word); end
            end
        end
        tests_run++;
        if (obs_id.size() != 12) begin
            tests_failed++;
            $display("FAIL fair_count: got %0d beats exp 12", obs_id.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                tests_run++;
                if (obs_id[k] != k % N) begin tests_failed++; $display("FAIL fair_order beat%0d: got id %0d exp %0d", k, obs_id[k], k % N); end
            end
        end
    endtask

    task automatic test_packet_lock();
        int           exp_id [6];
        logic [W-1:0] exp_dat [6];
        exp_id  = '{0, 1, 1, 1, 2, 0};
        exp_dat = '{32'hA0, 32'h11, 32'h12, 32'h13, 32'h20, 32'hA1};
        apply_reset(1);
        push_pkt(0, 1, 32'hA0);
        push_pkt(0, 1, 32'hA1);
        push_pkt(1, 3, 32'h11);
        push_pkt(2, 1, 32'h20);
        for (int cyc = 0; cyc < 8; cyc++) begin
            run_cycle(1'b1, (cyc == 0) ? 4'b0001 : 4'b0111);
            tests_run++;
            if (cyc_got_rdy !== cyc_exp_rdy) begin tests_failed++; $display("FAIL lock_ready c%0d: got %b exp %b", cyc, cyc_got_rdy, cyc_exp_rdy); end
            tests_run++;
            if (cyc_got_ov !== cyc_exp_ov) begin tests_failed++; $display("FAIL lock_valid c%0d: got %b exp %b", cyc, cyc_got_ov, cyc_exp_ov); end
            if (cyc_chk_word) begin
                tests_run++;
                if (cyc_got_word !== cyc_exp_word) begin tests_failed++; $display("FAIL lock_beat c%0d: got %h exp %h", cyc, cyc_got_word, cyc_exp_word); end
            end
        end
        tests_run++;
        if (obs_id.size() != 6) begin
            tests_failed++;
            $display("FAIL lock_count: got %0d beats exp 6", obs_id.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                tests_run++;
                if (obs_id[k] != exp_id[k] || obs_data[k] !== exp_dat[k]) begin
                    tests_failed++;
                    $display("FAIL lock_order beat%0d: got id %0d data %h exp id %0d data %h", k, obs_id[k], obs_data[k], exp_id[k], exp_dat[k]);
                end
            end
        end
    endtask

    task automatic test_bubble();
        logic [N-1:0] masks [7];
        masks = '{4'b1000, 4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
        apply_reset(1);
        push_pkt(3, 3, 32'h31);
        push_pkt(0, 1, 32'h01);
        for (int cyc = 0; cyc < 7; cyc++) begin
            run_cycle(1'b1, masks[cyc]);
            tests_run++;
            if (cyc_got_rdy !== cyc_exp_rdy) begin tests_failed++; $display("FAIL bubble_ready c%0d: got %b exp %b", cyc, cyc_got_rdy, cyc_exp_rdy); end
            if (cyc_chk_word) begin
                tests_run++;
                if (cyc_got_word !== cyc_exp_word) begin tests_failed++; $display("FAIL bubble_beat c%0d: got %h exp %h", cyc, cyc_got_word, cyc_exp_word); end
            end
            if (cyc == 1 || cyc == 2) begin
                tests_run++;
                if (cyc_got_rdy[0] !== 1'b0) begin tests_failed++; $display("FAIL bubble_no_switch c%0d: got in_ready[0]=%b exp 0", cyc, cyc_got_rdy[0]); end
            end
        end
        tests_run++;
        if (obs_id.size() != 4 || obs_id[0] != 3 || obs_id[1] != 3 || obs_id[2] != 3 || obs_id[3] != 0) begin
            tests_failed++;
            $display("FAIL bubble_order: got %0d beats (%p) exp ids 3,3,3,0", obs_id.size(), obs_id);
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1);
        push_pkt(0, 1, 32'd43);
        push_pkt(1, 1, 32'd99);
        run_cycle(1'b0, 4'b0001);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            run_cycle(1'b0, 4'b0011);
            tests_run++;
            if (cyc_got_rdy !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready c%0d: got %b exp 0000", cyc, cyc_got_rdy); end
            tests_run++;
            if (cyc_got_ov !== 1'b1 || cyc_got_word.data !== 32'd43 || cyc_got_word.id !== 2'd0) begin
                tests_failed++;
                $display("FAIL bp_hold c%0d: got valid %b id %0d data %0d exp valid 1 id 0 data 43", cyc, cyc_got_ov, cyc_got_word.id, cyc_got_word.data);
            end
        end
        for (int cyc = 4; cyc <= 5; cyc++) begin
            run_cycle(1'b1, 4'b0011);
            tests_run++;
            if (cyc_got_rdy !== cyc_exp_rdy) begin tests_failed++; $display("FAIL bp_release_ready c%0d: got %b exp %b", cyc, cyc_got_rdy, cyc_exp_rdy); end
        end
        tests_run++;
        if (obs_id.size() != 2 || obs_data[0] !== 32'd43 || obs_id[0] != 0 || obs_data[1] !== 32'd99 || obs_id[1] != 1) begin
            tests_failed++;
            $display("FAIL bp_drain: got %0d beats ids %p data %p exp 43/id0 then 99/id1", obs_id.size(), obs_id, obs_data);
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset(1);
        push_pkt(2, 3, 32'h2200);
        run_cycle(1'b1, 4'b0100);
        tests_run++;
        if (dbg_state !== ST_LOCKED) begin tests_failed++; $display("FAIL midrst_locked: got %0d exp LOCKED", dbg_state); end
        resetn    = 1'b0;
        in_valid  = 4'b0101;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== '0) begin tests_failed++; $display("FAIL midrst_in_ready: got %b exp 0000", in_ready); end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid: got %b exp 0", out_valid); end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL midrst_state: got %0d exp IDLE", dbg_state); end
        resetn = 1'b1;
        clear_all();
        push_pkt(0, 1, 32'h05);
        push_pkt(2, 1, 32'h22);
        run_cycle(1'b1, 4'b0101);
        tests_run++;
        if (cyc_got_rdy !== 4'b0001) begin tests_failed++; $display("FAIL midrst_first_grant: got %b exp 0001", cyc_got_rdy); end
        repeat (2) run_cycle(1'b1, 4'b0101);
        tests_run++;
        if (obs_id.size() != 2 || obs_id[0] != 0 || obs_data[0] !== 32'h05 || obs_id[1] != 2) begin
            tests_failed++;
            $display("FAIL midrst_order: got ids %p data %p exp id0/05 then id2", obs_id, obs_data);
        end
    endtask

    task automatic test_random();
        int  len, cnt;
        bit  done;
        apply_reset(1);
        for (int r = 0; r < N; r++) begin
            while (src_wr[r] < 10) begin
                len = $urandom_range(1, 3);
                push_pkt(r, len, W'($urandom));
            end
        end
        for (int cyc = 0; cyc < 150; cyc++) begin
            run_cycle(($urandom_range(0, 9) < 7), {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                                                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
            tests_run++;
            if (cyc_got_rdy !== cyc_exp_rdy) begin tests_failed++; $display("FAIL rand_ready c%0d: got %b exp %b", cyc, cyc_got_rdy, cyc_exp_rdy); end
            tests_run++;
            if (cyc_got_ov !== cyc_exp_ov) begin tests_failed++; $display("FAIL rand_valid c%0d: got %b exp %b", cyc, cyc_got_ov, cyc_exp_ov); end
            if (cyc_chk_word) begin
                tests_run++;
                if (cyc_got_word !== cyc_exp_word) begin tests_failed++; $display("FAIL rand_beat c%0d: got %h exp %h", cyc, cyc_got_word, cyc_exp_word); end
            end
        end
        // Drain everything that is left, with a bounded cycle budget.
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 300) begin
            done = (exp_q.size() == 0);
            for (int r = 0; r < N; r++) if (src_rd[r] < src_wr[r]) done = 1'b0;
            if (!done) begin
                run_cycle(1'b1, '1);
                cnt++;
                if (cyc_chk_word) begin
                    tests_run++;
                    if (cyc_got_word !== cyc_exp_word) begin tests_failed++; $display("FAIL rand_drain_beat: got %h exp %h", cyc_got_word, cyc_exp_word); end
                end
            end
        end
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL rand_drain_timeout: %0d beats still queued after %0d cycles", exp_q.size(), cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_fairness();
        test_packet_lock();
        test_bubble();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
